vme_bus_requester: RTL and testbench

//  Per-master bus requester; the requesting side of vme arbitration. Takes a local master's
//  bus request, drives one arbiter BusReq line, waits for its BusGrant, asserts BBSY
//  for the tenure, hands a local grant to the master, and releases the bus at end of transfer.

---
 rtl/vme_pkg.sv | 25 ++
 rtl/vme_sat_counter.sv | 22 ++
 rtl/vme_bus_requester.sv | 146 ++++++++++++++
 tb/tb_vme_bus_requester.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vme_pkg.sv
// Shared types for the VME arbitration slice: requester states, arbiter mode codes,
// master count and the BusReq/BusGrant lane mask helper.
package vme_pkg;

  localparam int unsigned NUM_MASTERS = 4;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    OWN,
    REL,
    PARK
  } req_state_e;

  typedef enum logic [1:0] {
    ARB_SINGLE      = 2'b00,
    ARB_PRIORITY    = 2'b01,
    ARB_ROUND_ROBIN = 2'b10
  } arb_mode_e;

  function automatic logic [NUM_MASTERS-1:0] level_mask(input int unsigned lvl);
    return {{(NUM_MASTERS-1){1'b0}}, 1'b1} << lvl;
  endfunction

endpackage

// File: rtl/vme_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable); holds at all-ones.
module vme_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vme_bus_requester.sv
// Per-master VME bus requester: BusReq -> BusGrant -> BBSY tenure -> release.
// Optional release-on-request parking is enabled by defining VME_ROR_EN.
module vme_bus_requester
  import vme_pkg::*;
#(
  parameter int unsigned REQ_LEVEL   = 2,
  parameter int unsigned GNT_TIMEOUT = 255,
  parameter int unsigned MAX_TENURE  = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   local_req,
  input  logic                   local_done,
  input  logic                   beat,
  input  logic [NUM_MASTERS-1:0] bus_grant,
  input  logic [NUM_MASTERS-1:0] bus_req_all,
  output logic [NUM_MASTERS-1:0] bus_req,
  output logic                   bbsy,
  output logic                   local_gnt,
  output logic                   timeout,
  output logic                   abort
);

  localparam logic [NUM_MASTERS-1:0] LANE     = level_mask(REQ_LEVEL);
  localparam logic [CNT_W-1:0]       TO_LAST  = CNT_W'(GNT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]       TEN_LAST = CNT_W'(MAX_TENURE - 1);

  req_state_e       state;
  logic             grant;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] count;

  assign grant = |(bus_grant & LANE);

`ifdef VME_ROR_EN
  logic other_req;
  assign other_req = |(bus_req_all & ~LANE);
`else
  logic unused_req_all;
  assign unused_req_all = ^bus_req_all;
`endif

  // One counter serves both the grant wait and the tenure: it is held clear in every
  // state that precedes REQ or OWN, and on the REQ->OWN edge itself.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state)
      REQ:     if (grant) cnt_clr = 1'b1; else cnt_en = 1'b1;
      OWN:     cnt_en = beat;
      default: cnt_clr = 1'b1;
    endcase
  end

  vme_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= '0;
      bbsy      <= 1'b0;
      local_gnt <= 1'b0;
      timeout   <= 1'b0;
      abort     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      abort   <= 1'b0;
      case (state)
        IDLE: begin
          if (local_req) begin
            state   <= REQ;
            bus_req <= LANE;
          end
        end
        REQ: begin
          if (grant) begin
            state     <= OWN;
            bus_req   <= '0;
            bbsy      <= 1'b1;
            local_gnt <= 1'b1;
          end else if (!local_req) begin
            state   <= IDLE;
            bus_req <= '0;
          end else if (count == TO_LAST) begin
            state   <= IDLE;
            bus_req <= '0;
            timeout <= 1'b1;
          end
        end
        OWN: begin
          if (!grant) begin
            state     <= IDLE;
            bbsy      <= 1'b0;
            local_gnt <= 1'b0;
            abort     <= 1'b1;
          end else if (local_done) begin
`ifdef VME_ROR_EN
            state     <= PARK;
            local_gnt <= 1'b0;
`else
            state     <= REL;
            bbsy      <= 1'b0;
            local_gnt <= 1'b0;
`endif
          end else if (beat && (count == TEN_LAST)) begin
            state     <= REL;
            bbsy      <= 1'b0;
            local_gnt <= 1'b0;
          end
        end
        REL: begin
          if (!grant) state <= IDLE;
        end
`ifdef VME_ROR_EN
        PARK: begin
          // Another master's request beats our own re-use of the parked bus.
          if (other_req || !grant) begin
            state <= REL;
            bbsy  <= 1'b0;
          end else if (local_req) begin
            state     <= OWN;
            local_gnt <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          bus_req   <= '0;
          bbsy      <= 1'b0;
          local_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_bus_requester.sv
// Scoreboarded bench for vme_bus_requester (REQ_LEVEL=2, GNT_TIMEOUT=8, MAX_TENURE=4).
module tb_vme_bus_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       local_req, local_done, beat;
  logic [3:0] bus_grant, bus_req_all;
  logic [3:0] bus_req;
  logic       bbsy, local_gnt, timeout, abort;
  logic [7:0] obs;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got;

`ifdef VME_ROR_EN
  localparam bit ROR = 1'b1;
`else
  localparam bit ROR = 1'b0;
`endif

  // Expected output words: {bus_req, bbsy, local_gnt, timeout, abort}
  localparam logic [7:0] Z  = 8'b0000_0000;
  localparam logic [7:0] R  = 8'b0100_0000;
  localparam logic [7:0] O  = 8'b0000_1100;
  localparam logic [7:0] P  = 8'b0000_1000;
  localparam logic [7:0] T  = 8'b0000_0010;
  localparam logic [7:0] A  = 8'b0000_0001;
  localparam logic [3:0] G  = 4'b0100;
  localparam logic [3:0] NG = 4'b0000;

  vme_bus_requester #(
    .REQ_LEVEL   (2),
    .GNT_TIMEOUT (8),
    .MAX_TENURE  (4),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .local_req   (local_req),
    .local_done  (local_done),
    .beat        (beat),
    .bus_grant   (bus_grant),
    .bus_req_all (bus_req_all),
    .bus_req     (bus_req),
    .bbsy        (bbsy),
    .local_gnt   (local_gnt),
    .timeout     (timeout),
    .abort       (abort)
  );

  always #5 clk = ~clk;
  assign obs = {bus_req, bbsy, local_gnt, timeout, abort};

  task automatic drv(input logic r, input logic d, input logic b,
                     input logic [3:0] g, input logic [3:0] a);
    @(negedge clk);
    local_req = r; local_done = d; beat = b; bus_grant = g; bus_req_all = a;
  endtask

  task automatic test_reset();
    rst = 1'b1; local_req = 1'b0; local_done = 1'b0; beat = 1'b0;
    bus_grant = '0; bus_req_all = '0;
    #1;
    exp_q.push_back(Z);
    got = exp_q.pop_front(); n_cmp++;
    if (obs !== got) begin
      n_err++; $display("FAIL reset_async: observed %b required %b", obs, got);
    end
    for (int i = 0; i < 3; i++) begin
      drv(i < 2, 1'b0, 1'b0, G, 4'b0000);
      if (i == 2) rst = 1'b0;
      exp_q.push_back(Z);
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL reset_hold[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_grant_flow();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0, 1, 2: begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        3:       begin drv(1, 0, 0, G,  4'b0000); exp_q.push_back(O); end
        4:       begin drv(0, 0, 1, G,  4'b0000); exp_q.push_back(O); end
        5:       begin drv(0, 1, 0, G,  4'b1000); exp_q.push_back(ROR ? P : Z); end
        6:       begin drv(0, 0, 0, G,  4'b1000); exp_q.push_back(Z); end
        7:       begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
        8:       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        default: begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
      endcase
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL grant_flow[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 11; i++) begin
      if (i < 8)       begin drv(1, 0, 0, 4'b0010, 4'b0000); exp_q.push_back(R); end
      else if (i == 8) begin drv(1, 0, 0, 4'b0010, 4'b0000); exp_q.push_back(T); end
      else if (i == 9) begin drv(1, 0, 0, NG, 4'b0000);      exp_q.push_back(R); end
      else             begin drv(0, 0, 0, NG, 4'b0000);      exp_q.push_back(Z); end
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL timeout[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_grant_at_timeout();
    for (int i = 0; i < 11; i++) begin
      if (i < 8)       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
      else if (i == 8) begin drv(1, 0, 0, G,  4'b0000); exp_q.push_back(O); end
      else if (i == 9) begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(A); end
      else             begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL grant_at_timeout[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_tenure();
    for (int i = 0; i < 11; i++) begin
      case (i)
        0:          begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        1:          begin drv(1, 0, 0, G,  4'b0000); exp_q.push_back(O); end
        2, 3, 4:    begin drv(0, 0, 1, G,  4'b0000); exp_q.push_back(O); end
        5:          begin drv(0, 0, 1, G,  4'b0000); exp_q.push_back(Z); end
        6, 7:       begin drv(1, 0, 1, G,  4'b0000); exp_q.push_back(Z); end
        8:          begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
        9:          begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        default:    begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
      endcase
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL tenure[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        1:       begin drv(1, 0, 0, G,  4'b0000); exp_q.push_back(O); end
        2:       begin drv(0, 1, 0, NG, 4'b0000); exp_q.push_back(A); end
        3:       begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
        4:       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        default: begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
      endcase
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL abort[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  task automatic test_reset_mid_own();
    for (int i = 0; i < 2; i++) begin
      drv(1, 0, 0, (i == 1) ? G : NG, 4'b0000);
      exp_q.push_back((i == 1) ? O : R);
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL reset_mid_own_setup[%0d]: observed %b required %b", i, obs, got);
      end
    end
    #1 rst = 1'b1;
    #1;
    exp_q.push_back(Z);
    got = exp_q.pop_front(); n_cmp++;
    if (obs !== got) begin
      n_err++; $display("FAIL reset_mid_own_async: observed %b required %b", obs, got);
    end
    drv(0, 0, 0, NG, 4'b0000);
    rst = 1'b0;
    exp_q.push_back(Z);
    @(posedge clk); #1;
    got = exp_q.pop_front(); n_cmp++;
    if (obs !== got) begin
      n_err++; $display("FAIL reset_mid_own_after: observed %b required %b", obs, got);
    end
  endtask

  task automatic test_release_on_request();
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        1:       begin drv(1, 0, 0, G,  4'b0000); exp_q.push_back(O); end
        2:       begin drv(0, 1, 0, G,  4'b0000); exp_q.push_back(ROR ? P : Z); end
        3:       begin drv(1, 0, 0, G,  4'b0100); exp_q.push_back(ROR ? O : Z); end
        4:       begin drv(0, 1, 0, G,  4'b0000); exp_q.push_back(ROR ? P : Z); end
        5:       begin drv(1, 0, 0, G,  4'b1000); exp_q.push_back(Z); end
        6:       begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
        7:       begin drv(1, 0, 0, NG, 4'b0000); exp_q.push_back(R); end
        default: begin drv(0, 0, 0, NG, 4'b0000); exp_q.push_back(Z); end
      endcase
      @(posedge clk); #1;
      got = exp_q.pop_front(); n_cmp++;
      if (obs !== got) begin
        n_err++; $display("FAIL release_on_request[%0d]: observed %b required %b", i, obs, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_grant_flow();
    test_timeout();
    test_grant_at_timeout();
    test_tenure();
    test_abort();
    test_reset_mid_own();
    test_release_on_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
